// File: rtl/imem_fetch_queue.sv
// imem_fetch_queue: instruction-fetch front end between the program counter
// and instruction memory.
// - Each accepted fetch address is sent to memory and recorded in an in-order
//   ring of depth_p entries.
// - The in-order response fills the oldest open entry.
// - Decode drains the ring through a valid/ready handshake.
// - A flush empties the ring and counts the in-flight responses that must be
//   discarded when they come back.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a response
// straight to decode when the ring is empty.
module imem_fetch_queue #(
  parameter int width_p = 32,
  parameter int depth_p = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [width_p-1:0] pc_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               req_valid_o,
  input  logic               req_ready_i,
  output logic [width_p-1:0] req_addr_o,
  input  logic               resp_valid_i,
  input  logic [width_p-1:0] resp_data_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [width_p-1:0] instr_o,
  output logic [width_p-1:0] instr_pc_o
);

  localparam int idx_w_lp = $clog2(depth_p);
  localparam int ptr_w_lp = idx_w_lp + 1;
  localparam int cnt_w_lp = $clog2(depth_p + 1);
  localparam int sum_w_lp = ptr_w_lp + 1;

  // Pointers carry a wrap bit so that full and empty can be told apart.
  logic [ptr_w_lp-1:0] alloc_ptr_reg, alloc_ptr_next;
  logic [ptr_w_lp-1:0] fill_ptr_reg, fill_ptr_next;
  logic [ptr_w_lp-1:0] read_ptr_reg, read_ptr_next;
  logic [cnt_w_lp-1:0] drop_cnt_reg, drop_cnt_next;

  logic [width_p-1:0] pc_mem   [depth_p];
  logic [width_p-1:0] data_mem [depth_p];
  logic [depth_p-1:0] filled_reg;

  logic [idx_w_lp-1:0] alloc_idx, fill_idx, read_idx;
  logic [ptr_w_lp-1:0] alloc_minus_read, alloc_minus_fill;
  logic [sum_w_lp-1:0] drop_ext, in_use, drop_sum;
  logic credit, issue, outstanding;
  logic resp_drop, resp_take, resp_store, resp_dec;
  logic stored_valid, drain;

  assign alloc_idx = alloc_ptr_reg[idx_w_lp-1:0];
  assign fill_idx  = fill_ptr_reg[idx_w_lp-1:0];
  assign read_idx  = read_ptr_reg[idx_w_lp-1:0];

  // Slots still owed a response after a flush keep consuming credit, so the
  // number of in-flight requests never exceeds depth_p.
  assign alloc_minus_read = alloc_ptr_reg - read_ptr_reg;
  assign alloc_minus_fill = alloc_ptr_reg - fill_ptr_reg;
  assign drop_ext = {{(sum_w_lp-cnt_w_lp){1'b0}}, drop_cnt_reg};
  assign in_use   = {1'b0, alloc_minus_read} + drop_ext;
  assign credit   = in_use < sum_w_lp'(depth_p);

  // Credit comes only from registered state, so a full-queue stall is
  // independent of resp_valid_i. Requests are held off while in reset.
  assign req_valid_o = rst_ni & credit & ~flush_i;
  assign req_addr_o  = pc_i;
  assign issue       = req_valid_o & req_ready_i;
  assign stall_o     = ~issue;

  // A response with nothing outstanding is ignored.
  assign outstanding = alloc_ptr_reg != fill_ptr_reg;
  assign resp_drop   = resp_valid_i & ~flush_i & (drop_cnt_reg != '0);
  assign resp_take   = resp_valid_i & ~flush_i & (drop_cnt_reg == '0) & outstanding;

  // On a flush, every unfilled slot becomes a pending drop. A response
  // arriving in the same cycle answers one of those drops.
  assign drop_sum = drop_ext + {1'b0, alloc_minus_fill};
  assign resp_dec = resp_valid_i & (drop_sum != '0);

  assign stored_valid = (read_ptr_reg != fill_ptr_reg) & filled_reg[read_idx];

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_hit;
  // When the ring is empty, read_idx equals fill_idx. The pc of the entry
  // being answered is therefore already selected by instr_pc_o.
  assign bypass_hit    = resp_take & (read_ptr_reg == fill_ptr_reg);
  assign instr_valid_o = ~flush_i & (stored_valid | bypass_hit);
  assign instr_o       = bypass_hit ? resp_data_i : data_mem[read_idx];
  assign instr_pc_o    = pc_mem[read_idx];
  assign resp_store    = resp_take & ~(bypass_hit & instr_ready_i);
`else
  assign instr_valid_o = ~flush_i & stored_valid;
  assign instr_o       = data_mem[read_idx];
  assign instr_pc_o    = pc_mem[read_idx];
  assign resp_store    = resp_take;
`endif

  assign drain = instr_valid_o & instr_ready_i;

  // Next-state for the pointers and the drop counter. A flush overrides the
  // issue, response and drain updates.
  always_comb begin
    alloc_ptr_next = alloc_ptr_reg;
    fill_ptr_next  = fill_ptr_reg;
    read_ptr_next  = read_ptr_reg;
    drop_cnt_next  = drop_cnt_reg;
    if (flush_i) begin
      alloc_ptr_next = fill_ptr_reg;
      read_ptr_next  = fill_ptr_reg;
      drop_cnt_next  = cnt_w_lp'(drop_sum - sum_w_lp'(resp_dec));
    end else begin
      if (issue)     alloc_ptr_next = alloc_ptr_reg + ptr_w_lp'(1);
      if (resp_drop) drop_cnt_next  = drop_cnt_reg - cnt_w_lp'(1);
      if (resp_take) fill_ptr_next  = fill_ptr_reg + ptr_w_lp'(1);
      if (drain)     read_ptr_next  = read_ptr_reg + ptr_w_lp'(1);
    end
  end

  // Pointer and drop-counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      read_ptr_reg  <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      alloc_ptr_reg <= alloc_ptr_next;
      fill_ptr_reg  <= fill_ptr_next;
      read_ptr_reg  <= read_ptr_next;
      drop_cnt_reg  <= drop_cnt_next;
    end
  end

  // Ring storage.
  // - Allocation records the pc and opens the entry.
  // - A stored response writes the data and marks the entry filled.
  // - Entries are cleared on reset so that instr_o and instr_pc_o read 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < depth_p; i++) begin
        pc_mem[i]     <= '0;
        data_mem[i]   <= '0;
        filled_reg[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < depth_p; i++) begin
        if (issue && (alloc_idx == idx_w_lp'(i))) begin
          pc_mem[i]     <= pc_i;
          filled_reg[i] <= 1'b0;
        end
        if (resp_store && (fill_idx == idx_w_lp'(i))) begin
          data_mem[i]   <= resp_data_i;
          filled_reg[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_queue.sv
// tb_imem_fetch_queue: directed, self-checking bench for imem_fetch_queue.
// Expected values are hand-computed per cycle. Under FETCH_QUEUE_BYPASS_EN the
// response-to-decode latency shrinks by one cycle.
module tb_imem_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic        req_valid_o;
  logic        req_ready_i = 1'b0;
  logic [31:0] req_addr_o;
  logic        resp_valid_i = 1'b0;
  logic [31:0] resp_data_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  int checks = 0;
  int failures = 0;
  int outst = 0;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int lat_lp = 1;
  localparam bit bypass_lp = 1'b1;
`else
  localparam int lat_lp = 2;
  localparam bit bypass_lp = 1'b0;
`endif

  imem_fetch_queue #(.width_p(32), .depth_p(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .pc_i          (pc_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_addr_o    (req_addr_o),
    .resp_valid_i  (resp_valid_i),
    .resp_data_i   (resp_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [31:0] pc, input logic fl, input logic rr,
                       input logic rv, input logic [31:0] rd, input logic ir);
    pc_i          = pc;
    flush_i       = fl;
    req_ready_i   = rr;
    resp_valid_i  = rv;
    resp_data_i   = rd;
    instr_ready_i = ir;
    #1;
  endtask

  // Transaction log and response-protocol check, then advance one cycle.
  task automatic step();
    if (rst_ni) begin
      if (resp_valid_i) begin
        check("resp_outstanding", 32'(outst != 0), 32'd1);
        if (outst > 0) outst--;
      end
      if (req_valid_o && req_ready_i) begin
        outst++;
        $display("issue  addr=0x%08h", req_addr_o);
      end
      if (instr_valid_o && instr_ready_i)
        $display("decode pc=0x%08h instr=0x%08h", instr_pc_o, instr_o);
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("rst_req_valid", 32'(req_valid_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd1);
    check("rst_instr_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_instr_pc", instr_pc_o, 32'h0);
    outst = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic        ev;
    logic [31:0] epc, ed;

    // Streaming: four fetches, one-cycle memory, decode always ready.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(32'(4 * c), 1'b0, c < 4, (c >= 1) && (c <= 4), 32'hA0 + 32'(c) - 32'd1, 1'b1);
      if (c < 4) begin
        check("t1_stall", 32'(stall_o), 32'd0);
        check("t1_req_addr", req_addr_o, 32'(4 * c));
      end
      ev = (c >= lat_lp) && (c < lat_lp + 4);
      check("t1_instr_valid", 32'(instr_valid_o), 32'(ev));
      if (ev) begin
        check("t1_instr_pc", instr_pc_o, 32'(4 * (c - lat_lp)));
        check("t1_instr", instr_o, 32'hA0 + 32'(c - lat_lp));
      end
      step();
    end

    // Full queue: four allocations, decode stalled, then a single drain.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive((c < 4) ? 32'h10 + 32'(4 * c) : 32'h20, 1'b0, 1'b1, c == 1, 32'hB0, c == 5);
      if (c < 4) check("t2_stall_early", 32'(stall_o), 32'd0);
      if (c == 4 || c == 5) begin
        check("t2_stall_full", 32'(stall_o), 32'd1);
        check("t2_req_valid_full", 32'(req_valid_o), 32'd0);
        check("t2_head_valid", 32'(instr_valid_o), 32'd1);
        check("t2_head_pc", instr_pc_o, 32'h10);
        check("t2_head_instr", instr_o, 32'hB0);
      end
      if (c == 6) begin
        check("t2_resume_stall", 32'(stall_o), 32'd0);
        check("t2_resume_addr", req_addr_o, 32'h20);
      end
      step();
    end

    // Flush with three requests in flight, redirect to 0x100.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive((c < 3) ? 32'(4 * c) : 32'h100, c == 3, c <= 4, (c >= 4) && (c <= 7),
            (c == 7) ? 32'hD0 : 32'hC0 + 32'(c - 4), 1'b1);
      if (c == 3) begin
        check("t3_flush_req_valid", 32'(req_valid_o), 32'd0);
        check("t3_flush_stall", 32'(stall_o), 32'd1);
      end
      if (c == 4) begin
        check("t3_drop_cnt_after_flush", 32'(dut.drop_cnt_reg), 32'd3);
        check("t3_redirect_req_valid", 32'(req_valid_o), 32'd1);
        check("t3_redirect_addr", req_addr_o, 32'h100);
      end
      if (c == 7) check("t3_drop_cnt_drained", 32'(dut.drop_cnt_reg), 32'd0);
      ev = (c == lat_lp + 6);
      check("t3_instr_valid", 32'(instr_valid_o), 32'(ev));
      if (ev) begin
        check("t3_instr_pc", instr_pc_o, 32'h100);
        check("t3_instr", instr_o, 32'hD0);
      end
      step();
    end

    // Flush coinciding with a response and a ready decode.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive((c == 0) ? 32'h200 : (c == 1) ? 32'h204 : 32'h300, c == 2,
            (c <= 1) || (c == 3), (c == 1) || (c == 2) || (c == 4),
            (c == 1) ? 32'hE0 : (c == 2) ? 32'hE1 : 32'hF0, c >= 2);
      ev = (c == lat_lp + 3) || (bypass_lp && (c == 1));
      check("t4_instr_valid", 32'(instr_valid_o), 32'(ev));
      if (ev) begin
        epc = (c == 1) ? 32'h200 : 32'h300;
        ed  = (c == 1) ? 32'hE0 : 32'hF0;
        check("t4_instr_pc", instr_pc_o, epc);
        check("t4_instr", instr_o, ed);
      end
      if (c == 2) check("t4_flush_req_valid", 32'(req_valid_o), 32'd0);
      if (c == 3) begin
        check("t4_drop_cnt", 32'(dut.drop_cnt_reg), 32'd0);
        check("t4_read_ptr", 32'(dut.read_ptr_reg), 32'd1);
        check("t4_req_addr", req_addr_o, 32'h300);
        check("t4_req_valid", 32'(req_valid_o), 32'd1);
      end
      step();
    end

    // Memory not ready for five cycles, with address 0x40 held.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(32'h40, 1'b0, c == 5, c == 6, 32'h44, 1'b1);
      if (c < 5) begin
        check("t5_stall_blocked", 32'(stall_o), 32'd1);
        check("t5_req_valid", 32'(req_valid_o), 32'd1);
        check("t5_req_addr", req_addr_o, 32'h40);
      end
      if (c == 5) begin
        check("t5_no_alloc", 32'(dut.alloc_ptr_reg), 32'd0);
        check("t5_stall_ready", 32'(stall_o), 32'd0);
      end
      if (c == 6) check("t5_alloc_once", 32'(dut.alloc_ptr_reg), 32'd1);
      ev = (c == lat_lp + 5);
      check("t5_instr_valid", 32'(instr_valid_o), 32'(ev));
      if (ev) begin
        check("t5_instr_pc", instr_pc_o, 32'h40);
        check("t5_instr", instr_o, 32'h44);
      end
      step();
    end

    // Response to an empty queue: same cycle with bypass, one cycle later without.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(32'h80, 1'b0, c == 0, c == 1, 32'hDEAD, 1'b1);
      ev = (c == lat_lp);
      check("t6_instr_valid", 32'(instr_valid_o), 32'(ev));
      if (ev) begin
        check("t6_instr", instr_o, 32'hDEAD);
        check("t6_instr_pc", instr_pc_o, 32'h80);
      end
      if (c == lat_lp + 1) begin
        check("t6_read_ptr", 32'(dut.read_ptr_reg), 32'd1);
        check("t6_fill_ptr", 32'(dut.fill_ptr_reg), 32'd1);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
